// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot path: word/address widths and the
// program-loader state encoding.
package mips_pkg;

    localparam int WORD_W           = 32;
    localparam int IMEM_BYTE_ADDR_W = 32;
    localparam int HDR_COUNT_W      = 16;
    localparam int BYTES_PER_WORD   = WORD_W / 8;

    typedef enum logic [2:0] {
        LD_HDR_HI,
        LD_HDR_LO,
        LD_DATA,
        LD_RUN,
        LD_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes MSB-first into one instruction word; the
// completed word is presented combinationally alongside the fourth byte.
module byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        in_byte,
    output logic [WORD_W-1:0] word,
    output logic              word_complete
);

    logic [WORD_W-1:0] shreg_reg;
    logic [WORD_W-1:0] shreg_next;
    logic [1:0]        byte_idx_reg;

    // Each lane takes the byte from the lane below; lane 0 takes the new byte,
    // so the first byte of a word has moved up to [31:24] by the fourth.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi == 0) begin : g_low
                assign shreg_next[7:0] = in_byte;
            end else begin : g_upper
                assign shreg_next[gi*8 +: 8] = shreg_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            shreg_reg    <= '0;
            byte_idx_reg <= '0;
        end else if (shift_en) begin
            shreg_reg    <= shreg_next;
            byte_idx_reg <= byte_idx_reg + 2'd1;
        end
    end

    assign word          = shreg_next;
    assign word_complete = shift_en && (byte_idx_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a 16-bit word-count header plus big-endian words
// from a byte link, writes them to instruction memory and holds the CPU until done.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [7:0]                  in_byte,
    output logic                        in_ready,
    input  logic                        reload,
    output logic                        imem_we,
    output logic [IMEM_BYTE_ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0]           imem_wdata,
    output logic                        cpu_hold,
    output logic                        done,
    output logic                        err
);

    localparam int WIDX_W = $clog2(DEPTH_WORDS) + 1;
    localparam logic [HDR_COUNT_W:0] DEPTH_LIM = (HDR_COUNT_W+1)'(DEPTH_WORDS);

    loader_state_t state_reg, state_next;
    logic [HDR_COUNT_W-1:0]      count_reg, count_next;
    logic [WIDX_W-1:0]           word_idx_reg, word_idx_next;
    logic                        imem_we_reg, imem_we_next;
    logic [IMEM_BYTE_ADDR_W-1:0] imem_addr_reg, imem_addr_next;
    logic [WORD_W-1:0]           imem_wdata_reg, imem_wdata_next;
    logic                        done_reg, done_next;
    logic                        err_reg, err_next;

    logic                   byte_fire;
    logic                   shift_en;
    logic                   reload_fire;
    logic                   pack_clear;
    logic [WORD_W-1:0]      packed_word;
    logic                   word_complete;
    logic [HDR_COUNT_W-1:0] count_full;
    logic [HDR_COUNT_W-1:0] words_after;

    assign in_ready    = (state_reg == LD_HDR_HI) || (state_reg == LD_HDR_LO)
                      || (state_reg == LD_DATA);
    assign byte_fire   = in_valid && in_ready;
    assign shift_en    = byte_fire && (state_reg == LD_DATA);
    assign reload_fire = reload && ((state_reg == LD_RUN) || (state_reg == LD_ERR));
    // A reset or reload throws away any partially assembled word.
    assign pack_clear  = !rst_n || reload_fire;

    assign count_full  = {count_reg[15:8], in_byte};
    assign words_after = HDR_COUNT_W'(word_idx_reg) + HDR_COUNT_W'(1);

    byte_packer u_packer (
        .clk           (clk),
        .clear         (pack_clear),
        .shift_en      (shift_en),
        .in_byte       (in_byte),
        .word          (packed_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= LD_HDR_HI;
            count_reg      <= '0;
            word_idx_reg   <= '0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            word_idx_reg   <= word_idx_next;
            imem_we_reg    <= imem_we_next;
            imem_addr_reg  <= imem_addr_next;
            imem_wdata_reg <= imem_wdata_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        word_idx_next   = word_idx_reg;
        imem_we_next    = 1'b0;
        imem_addr_next  = imem_addr_reg;
        imem_wdata_next = imem_wdata_reg;
        done_next       = 1'b0;
        err_next        = err_reg;

        unique case (state_reg)
            LD_HDR_HI: begin
                if (byte_fire) begin
                    count_next = {in_byte, count_reg[7:0]};
                    state_next = LD_HDR_LO;
                end
            end

            LD_HDR_LO: begin
                if (byte_fire) begin
                    count_next = count_full;
                    if (count_full == '0) begin
                        state_next = LD_RUN;
                        done_next  = 1'b1;
                    end else if ({1'b0, count_full} > DEPTH_LIM) begin
                        state_next = LD_ERR;
                        err_next   = 1'b1;
                    end else begin
                        state_next    = LD_DATA;
                        word_idx_next = '0;
                    end
                end
            end

            LD_DATA: begin
                if (word_complete) begin
                    imem_we_next    = 1'b1;
                    imem_wdata_next = packed_word;
                    imem_addr_next  = IMEM_BYTE_ADDR_W'({word_idx_reg, 2'b00});
                    word_idx_next   = word_idx_reg + WIDX_W'(1);
                    // Last word: leave hold in the same edge as the final strobe.
                    if (words_after == count_reg) begin
                        state_next = LD_RUN;
                        done_next  = 1'b1;
                    end
                end
            end

            LD_RUN, LD_ERR: begin
                if (reload_fire) begin
                    state_next    = LD_HDR_HI;
                    count_next    = '0;
                    word_idx_next = '0;
                    err_next      = 1'b0;
                end
            end

            default: begin
                state_next = LD_HDR_HI;
            end
        endcase
    end

    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign cpu_hold   = (state_reg != LD_RUN);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-level model predicts every
// output each cycle, plus literal checks of the resulting write log.
module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        reload = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the bytes accepted since the current load began.
    logic [7:0]  q[$];
    bit          model_on  = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_hold  = 1'b1;
    logic        exp_err   = 1'b0;
    logic        exp_we    = 1'b0;
    logic        exp_done  = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;

    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          done_seen = 0;
    bit          prev_we   = 1'b0;

    function automatic int hdr_cnt();
        return (int'(q[0]) << 8) | int'(q[1]);
    endfunction

    function automatic bit finished();
        if (q.size() < 2) return 1'b0;
        return (hdr_cnt() == 0) || (hdr_cnt() <= DEPTH && q.size() == 2 + 4 * hdr_cnt());
    endfunction

    function automatic bit errd();
        return (q.size() >= 2) && (hdr_cnt() > DEPTH);
    endfunction

    always @(negedge clk) begin
        int k;
        if (model_on) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
            chk("err", 32'(err), 32'(exp_err));
            chk("imem_we", 32'(imem_we), 32'(exp_we));
            chk("done", 32'(done), 32'(exp_done));
            chk("imem_addr", imem_addr, exp_addr);
            chk("imem_wdata", imem_wdata, exp_wdata);
            chk("we_back_to_back", 32'(prev_we && (imem_we === 1'b1)), 32'd0);
            prev_we = (imem_we === 1'b1);
            if (imem_we === 1'b1) begin
                wr_addr_log.push_back(imem_addr);
                wr_data_log.push_back(imem_wdata);
                $display("write @0x%08h = 0x%08h", imem_addr, imem_wdata);
            end
            if (done === 1'b1) done_seen++;
        end
        // Predict the effect of the coming rising edge.
        exp_we   = 1'b0;
        exp_done = 1'b0;
        if (!rst_n) begin
            q.delete();
            exp_addr  = '0;
            exp_wdata = '0;
            model_on  = 1'b1;
        end else if (model_on) begin
            if (reload && (finished() || errd())) begin
                q.delete();
            end else if (in_valid && exp_ready) begin
                q.push_back(in_byte);
                if (q.size() > 2 && !errd() && (q.size() - 2) % 4 == 0) begin
                    k         = (q.size() - 2) / 4 - 1;
                    exp_we    = 1'b1;
                    exp_addr  = 32'(k * 4);
                    exp_wdata = {q[q.size()-4], q[q.size()-3], q[q.size()-2], q[q.size()-1]};
                end
                exp_done = finished();
            end
        end
        exp_err   = errd();
        exp_hold  = !finished();
        exp_ready = !finished() && !errd();
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        chk("send_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
        idle(gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] img_norm [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                  8'h01, 8'h09, 8'h50, 8'h20};
    logic [7:0] img_cafe [6]  = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    logic [7:0] img_dead [6]  = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] img_aabb [6]  = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal two-word load, back-to-back bytes.
        foreach (img_norm[i]) send(img_norm[i], 0);
        idle(3);
        chk("normal_nwrites", 32'(wr_data_log.size()), 32'd2);
        chk("normal_addr0", wr_addr_log[0], 32'h0000_0000);
        chk("normal_data0", wr_data_log[0], 32'h2008_0005);
        chk("normal_addr1", wr_addr_log[1], 32'h0000_0004);
        chk("normal_data1", wr_data_log[1], 32'h0109_5020);
        chk("normal_done", 32'(done_seen), 32'd1);

        // Same image with a bubble after every byte.
        pulse_reload();
        foreach (img_norm[i]) send(img_norm[i], 1);
        idle(3);
        chk("bp_nwrites", 32'(wr_data_log.size()), 32'd4);
        chk("bp_addr0", wr_addr_log[2], 32'h0000_0000);
        chk("bp_data0", wr_data_log[2], 32'h2008_0005);
        chk("bp_addr1", wr_addr_log[3], 32'h0000_0004);
        chk("bp_data1", wr_data_log[3], 32'h0109_5020);

        // Zero-length image.
        pulse_reload();
        send(8'h00, 0);
        send(8'h00, 0);
        idle(3);
        chk("zero_nwrites", 32'(wr_data_log.size()), 32'd4);
        chk("zero_done", 32'(done_seen), 32'd3);
        chk("zero_hold", 32'(cpu_hold), 32'd0);

        // Oversize header, byte held while in ERR, then recovery by reload.
        pulse_reload();
        send(8'h01, 0);
        send(8'h01, 0);
        in_valid = 1'b1;
        in_byte  = 8'h55;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("ovr_err", 32'(err), 32'd1);
        chk("ovr_hold", 32'(cpu_hold), 32'd1);
        pulse_reload();
        chk("ovr_err_cleared", 32'(err), 32'd0);
        foreach (img_cafe[i]) send(img_cafe[i], 0);
        idle(3);
        chk("ovr_nwrites", 32'(wr_data_log.size()), 32'd5);
        chk("ovr_data", wr_data_log[4], 32'hCAFE_F00D);

        // Reload from RUN.
        pulse_reload();
        chk("rl_hold", 32'(cpu_hold), 32'd1);
        foreach (img_dead[i]) send(img_dead[i], 0);
        idle(3);
        chk("rl_addr", wr_addr_log[5], 32'h0000_0000);
        chk("rl_data", wr_data_log[5], 32'hDEAD_BEEF);
        chk("rl_done", 32'(done_seen), 32'd5);

        // Reset in the middle of a word.
        pulse_reload();
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        pulse_reset();
        idle(2);
        chk("rst_nwrites", 32'(wr_data_log.size()), 32'd6);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        foreach (img_aabb[i]) send(img_aabb[i], 0);
        idle(3);
        chk("rst_addr", wr_addr_log[6], 32'h0000_0000);
        chk("rst_data", wr_data_log[6], 32'hAABB_CCDD);
        chk("rst_done", 32'(done_seen), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
